// File: rtl/maltsev_pkg.sv
// Shared definitions for Maltsev-algebra operator sequencers.
package maltsev_pkg;

    typedef logic [1:0] mu_state_t;

    localparam mu_state_t LAUNCH = 2'd0;
    localparam mu_state_t WAIT   = 2'd1;
    localparam mu_state_t DONE   = 2'd2;
    localparam mu_state_t FAIL   = 2'd3;

endpackage

// File: rtl/rise_det.sv
// Registered rising-edge detector for level-style completion flags.
// While armed, the remembered level is forced high, so a level already high counts only after it drops and rises again.
module rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic arm,
    input  logic d,
    output logic rise
);

    logic old;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            old <= 1'b1;
        end else if (arm) begin
            old <= 1'b1;
        end else begin
            old <= d;
        end
    end

    assign rise = d & ~old;

endmodule

// File: rtl/mu_seq.sv
// Minimisation (mu) sequencer: restarts a child operator for y = 0, 1, 2, ...
// and reports the first y whose child result is zero, or overflow after MAXIT.
module mu_seq
    import maltsev_pkg::*;
#(
    parameter int W     = 8,
    parameter int MAXIT = 255
) (
    input  logic         CLK,
    input  logic         RST,
    output logic         CRST,
    output logic [W-1:0] CARG,
    input  logic         CRES,
    input  logic [W-1:0] CVAL,
    output logic         RES,
    output logic [W-1:0] OUT,
    output logic         OVF
);

    // state  | meaning
    // LAUNCH | child held in reset for one cycle with the current CARG
    // WAIT   | child running; waiting for a fresh CRES rising edge
    // DONE   | zero found at CARG; terminal until RST low
    // FAIL   | MAXIT tried without a zero; terminal until RST low
    mu_state_t    state;
    mu_state_t    state_nxt;
    logic         detect;
    logic         arm;
    logic         advance;
    logic [W-1:0] carg_q;

    // Only WAIT listens to the child; everywhere else the detector stays armed.
    assign arm = (state != WAIT);

    rise_det u_rise (
        .clk   (CLK),
        .rst_n (RST),
        .arm   (arm),
        .d     (CRES),
        .rise  (detect)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= LAUNCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        case (state)
            LAUNCH: state_nxt = WAIT;
            WAIT: begin
                if (detect) begin
                    if (CVAL == '0) begin
                        state_nxt = DONE;
                    end else if (carg_q == W'(MAXIT)) begin
                        state_nxt = FAIL;
                    end else begin
                        state_nxt = LAUNCH;
                        advance   = 1'b1;
                    end
                end
            end
            default: state_nxt = state;
        endcase
    end

    // CARG moves on the edge that drops CRST, so it is stable across the reset pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            carg_q <= '0;
        end else if (advance) begin
            carg_q <= carg_q + W'(1);
        end
    end

    always_comb begin
        CRST = (state != LAUNCH);
        RES  = (state == DONE) || (state == FAIL);
        OVF  = (state == FAIL);
        OUT  = (state == DONE) ? carg_q : '0;
        CARG = carg_q;
    end

endmodule

// File: tb/tb_mu_seq.sv
// Bench for mu_seq: behavioural child operator, table vectors, random searches and corner sequences.
module tb_mu_seq;

    localparam int W     = 8;
    localparam int MAXIT = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         CRST;
    logic [W-1:0] CARG;
    logic         CRES;
    logic [W-1:0] CVAL;
    logic         RES;
    logic [W-1:0] OUT;
    logic         OVF;

    always #5 CLK = ~CLK;

    mu_seq #(.W(W), .MAXIT(MAXIT)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .CRST (CRST),
        .CARG (CARG),
        .CRES (CRES),
        .CVAL (CVAL),
        .RES  (RES),
        .OUT  (OUT),
        .OVF  (OVF)
    );

    int checks = 0;
    int errors = 0;

    // Child operator model: result tab[y] appears c_lat cycles after CRST seen high.
    logic [7:0]   tab [0:255];
    int           c_lat = 2;
    bit           c_sticky = 1'b0;
    bit           ovr = 1'b0;
    logic         ov_cres = 1'b0;
    logic [W-1:0] ov_cval = '0;
    int           cnt = 0;
    logic         cres_m = 1'b0;
    logic         cres_d1 = 1'b0;
    logic [W-1:0] cval_m = '0;

    always @(posedge CLK) begin
        cres_d1 <= cres_m;
        if (!CRST) begin
            cnt    <= 0;
            cres_m <= 1'b0;
            cval_m <= '0;
        end else begin
            if (cnt < c_lat) cnt <= cnt + 1;
            if (cnt + 1 == c_lat) begin
                cres_m <= 1'b1;
                cval_m <= tab[CARG];
            end
        end
    end

    assign CRES = ovr ? ov_cres : (cres_m | (c_sticky & cres_d1));
    assign CVAL = ovr ? ov_cval : cval_m;

    // CRST pulse monitor: counts pulses after the first launch, widths, and CARG during each pulse.
    int pulses = 0;
    int lowrun = 0;
    int maxrun = 0;
    int carg_err = 0;
    bit seen_high = 1'b0;

    always @(negedge CLK) begin
        if (!RST) begin
            pulses    <= 0;
            lowrun    <= 0;
            maxrun    <= 0;
            carg_err  <= 0;
            seen_high <= 1'b0;
        end else if (CRST) begin
            seen_high <= 1'b1;
            lowrun    <= 0;
        end else if (seen_high) begin
            if (lowrun == 0) pulses <= pulses + 1;
            lowrun <= lowrun + 1;
            if (lowrun + 1 > maxrun) maxrun <= lowrun + 1;
            if (CARG != W'(pulses + ((lowrun == 0) ? 1 : 0))) carg_err <= carg_err + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic fill_linear(input int zy);
        for (int y = 0; y < 256; y++) tab[y] = 8'(zy - y);
    endtask

    // Reference: first y in 0..MAXIT with a zero result; n = number of restarts.
    function automatic void ref_search(output int eo, output bit eovf, output int en);
        eo   = 0;
        eovf = 1'b1;
        en   = MAXIT;
        for (int y = 0; y <= MAXIT; y++) begin
            if (tab[y] == 8'd0) begin
                eo   = y;
                eovf = 1'b0;
                en   = y;
                break;
            end
        end
    endfunction

    task automatic do_reset(input string name);
        ovr = 1'b0;
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check({name, "_reset"}, int'({CRST, CARG, RES, OUT, OVF}), 0);
    endtask

    task automatic release_rst();
        @(posedge CLK);
        #2 RST = 1'b1;
    endtask

    task automatic wait_done(input string name, input int lat, input int eo,
                             input bit eovf, input int en);
        int cyc = 0;
        bit got = 1'b0;
        while (cyc < 2000 && !got) begin
            @(posedge CLK);
            cyc++;
            @(negedge CLK);
            if (RES) got = 1'b1;
        end
        check({name, "_res_seen"}, int'(got), 1);
        if (got) begin
            check({name, "_cycles"}, cyc, en * (lat + 2) + lat + 2);
            check({name, "_out"}, int'(OUT), eo);
            check({name, "_ovf"}, int'(OVF), int'(eovf));
            check({name, "_carg"}, int'(CARG), eovf ? MAXIT : eo);
            check({name, "_crst_hi"}, int'(CRST), 1);
            #1;
            check({name, "_pulses"}, pulses, en);
            check({name, "_carg_in_pulse"}, carg_err, 0);
            if (en > 0) check({name, "_pulse_width"}, maxrun, 1);
        end
    endtask

    task automatic run_search(input string name, input int lat, input bit sticky,
                              input int eo, input bit eovf, input int en);
        do_reset(name);
        c_lat    = lat;
        c_sticky = sticky;
        release_rst();
        wait_done(name, lat, eo, eovf, en);
    endtask

    task automatic post_hold(input string name, input bit eovf, input int eo, input int ecarg);
        ovr = 1'b1;
        repeat (10) begin
            @(posedge CLK);
            #2;
            ov_cres = 1'($urandom_range(0, 1));
            ov_cval = W'($urandom_range(0, 3));
            @(negedge CLK);
            check(name, int'({RES, OVF, OUT, CRST, CARG}),
                  int'({1'b1, eovf, W'(eo), 1'b1, W'(ecarg)}));
        end
        ovr = 1'b0;
    endtask

    typedef struct {
        string name;
        int    lat;
        int    zero_y;
        bit    sticky;
        int    exp_out;
        bit    exp_ovf;
        int    exp_n;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int eo;
        bit eovf;
        int en;
        int lat;
        bit sticky;
        int cyc;
        bit got;

        vecs[0] = '{"three_minus_y",  2, 3,   1'b0, 3, 1'b0, 3};
        vecs[1] = '{"zero_first",     2, 0,   1'b0, 0, 1'b0, 0};
        vecs[2] = '{"exhaust",        2, 200, 1'b0, 0, 1'b1, 4};
        vecs[3] = '{"sticky_cres",    3, 2,   1'b1, 2, 1'b0, 2};
        vecs[4] = '{"zero_at_maxit",  1, 4,   1'b0, 4, 1'b0, 4};
        vecs[5] = '{"sticky_exhaust", 2, 200, 1'b1, 0, 1'b1, 4};
        vecs[6] = '{"long_latency",   6, 1,   1'b0, 1, 1'b0, 1};

        for (int i = 0; i < 7; i++) begin
            fill_linear(vecs[i].zero_y);
            run_search(vecs[i].name, vecs[i].lat, vecs[i].sticky,
                       vecs[i].exp_out, vecs[i].exp_ovf, vecs[i].exp_n);
        end

        // Terminal states ignore the child entirely.
        fill_linear(1);
        run_search("done_hold_setup", 2, 1'b0, 1, 1'b0, 1);
        post_hold("done_hold", 1'b0, 1, 1);
        fill_linear(200);
        run_search("fail_hold_setup", 2, 1'b0, 0, 1'b1, 4);
        post_hold("fail_hold", 1'b1, 0, 4);

        // Asynchronous abort while CARG=2, then restart from y=0.
        fill_linear(200);
        do_reset("abort");
        c_lat    = 3;
        c_sticky = 1'b0;
        release_rst();
        cyc = 0;
        got = 1'b0;
        while (cyc < 200 && !got) begin
            @(negedge CLK);
            cyc++;
            if (CARG == 8'd2 && CRST) got = 1'b1;
        end
        check("abort_reach_y2", int'(got), 1);
        #2 RST = 1'b0;
        #1 check("abort_async", int'({CRST, CARG, RES, OUT, OVF}), 0);
        fill_linear(1);
        repeat (2) @(posedge CLK);
        release_rst();
        @(negedge CLK);
        check("restart_launch", int'({CRST, CARG}), 0);
        wait_done("restart", 3, 1, 1'b0, 1);

        // Random child results against the reference search.
        for (int t = 0; t < 20; t++) begin
            lat    = $urandom_range(1, 5);
            sticky = (lat >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            fill_linear(200);
            for (int y = 0; y <= MAXIT; y++)
                tab[y] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            ref_search(eo, eovf, en);
            run_search("rand", lat, sticky, eo, eovf, en);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
